// File: rtl/i2c_slave_regport.sv
// I2C responder exposing a byte-wide register port: address write, pointer byte, then
// write data bytes or (after repeated START) read data bytes. SCL is sampled only.
module i2c_slave_regport #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;

  state_t      state;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic        sda_oe;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        rw;
  logic        mack;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // p0/p1 synchronize the bus pins, p2 holds the previous synchronized value
  always_ff @(posedge clk) begin
    scl_p0 <= scl;
    scl_p1 <= scl_p0;
    scl_p2 <= scl_p1;
    sda_p0 <= sda;
    sda_p1 <= sda_p0;
    sda_p2 <= sda_p1;
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      bit_cnt   <= 4'd0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (reg_we) reg_addr <= reg_addr + 8'd1;
      // The bank output is captured while reg_re is high; the pointer then moves on
      if (reg_re) begin
        shift    <= reg_rdata;
        reg_addr <= reg_addr + 8'd1;
      end
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd8;
        shift   <= 8'h00;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if ((state == ADDR || state == PTR || state == WDATA) && scl_rise && bit_cnt != 4'd0) begin
          shift   <= {shift[6:0], sda_p1};
          bit_cnt <= bit_cnt - 4'd1;
        end
        case (state)
          IDLE: ;
          ADDR:
            if (scl_fall && bit_cnt == 4'd0) begin
              if (shift[7:1] == DEV_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
                state  <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          ADDR_ACK:
            if (scl_fall) begin
              if (rw) begin
                reg_re  <= 1'b1;
                sda_oe  <= ~reg_rdata[7];
                bit_cnt <= 4'd7;
                state   <= RDATA;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd8;
                state   <= PTR;
              end
            end
          PTR:
            if (scl_fall && bit_cnt == 4'd0) begin
              reg_addr <= shift;
              sda_oe   <= 1'b1;
              state    <= PTR_ACK;
            end
          PTR_ACK:
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd8;
              state   <= WDATA;
            end
          WDATA:
            if (scl_fall && bit_cnt == 4'd0) begin
              sda_oe <= 1'b1;
              state  <= WDATA_ACK;
            end
          WDATA_ACK:
            if (scl_fall) begin
              sda_oe    <= 1'b0;
              reg_we    <= 1'b1;
              reg_wdata <= shift;
              bit_cnt   <= 4'd8;
              state     <= WDATA;
            end
          RDATA:
            if (scl_fall) begin
              if (bit_cnt != 4'd0) begin
                sda_oe  <= ~shift[6];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt - 4'd1;
              end else begin
                sda_oe <= 1'b0;
                state  <= RDATA_MACK;
              end
            end
          RDATA_MACK: begin
            if (scl_rise) mack <= sda_p1;
            // A master NACK leaves the line released until STOP or START
            if (scl_fall && !mack) begin
              reg_re  <= 1'b1;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= 4'd7;
              state   <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regport.sv
// Bench for i2c_slave_regport: bit-banged I2C master, emulated register bank and a
// transaction-level model of expected register-port strobes.
module tb_i2c_slave_regport;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic       load_bank;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  logic [7:0]  bank [256];
  logic [7:0]  mem  [256];
  logic [7:0]  m_ptr;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [15:0] cmp_w;
  logic [7:0]  cmp_r;
  int total = 0, bad = 0, pulls = 0, strobes = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign reg_rdata = bank[reg_addr];

  always #5 clk = ~clk;

  i2c_slave_regport #(.DEV_ADDR(7'h48)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_bus),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .reg_re(reg_re), .busy(busy)
  );

  function automatic logic [7:0] init_val(input int i);
    case (i)
      16'h10:  return 8'h11;
      16'h11:  return 8'h22;
      16'h20:  return 8'h77;
      16'h40:  return 8'hA5;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  always @(posedge clk) begin
    if (load_bank) begin
      for (int i = 0; i < 256; i++) bank[i] <= init_val(i);
    end else if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Every strobe on the register port must match the next expected transaction
  always @(negedge clk) begin
    if (!m_low && sda_bus === 1'b0) pulls++;
    if (reg_we || reg_re) strobes++;
    if (!reset && reg_we) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL we_unexpected: got addr %0h data %0h, want no write", reg_addr, reg_wdata);
      end else begin
        cmp_w = exp_wr.pop_front();
        chk("we_addr", 32'(reg_addr), 32'(cmp_w[15:8]));
        chk("we_data", 32'(reg_wdata), 32'(cmp_w[7:0]));
      end
    end
    if (!reset && reg_re) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL re_unexpected: got addr %0h, want no read", reg_addr);
      end else begin
        cmp_r = exp_rd.pop_front();
        chk("re_addr", 32'(reg_addr), 32'(cmp_r));
      end
    end
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wq();
    scl = 1'b1;   wq();
    m_low = 1'b1; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wq();
    scl = 1'b1;   wq();
    m_low = 1'b0; wq();
    wq();
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_low = ~b; wq();
    scl = 1'b1; wq();
    s = sda_bus; wq();
    scl = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(~mack, s);
  endtask

  task automatic wr_xfer(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1);
    logic a;
    exp_wr.push_back({ptr, d0});
    exp_wr.push_back({ptr + 8'd1, d1});
    mem[ptr] = d0;
    mem[ptr + 8'd1] = d1;
    m_ptr = ptr + 8'd2;
    i2c_start();
    wr_byte(8'h90, a); chk("wr_ack_addr", 32'(a), 1);
    chk("wr_busy", 32'(busy), 1);
    wr_byte(ptr, a);   chk("wr_ack_ptr", 32'(a), 1);
    wr_byte(d0, a);    chk("wr_ack_d0", 32'(a), 1);
    wr_byte(d1, a);    chk("wr_ack_d1", 32'(a), 1);
    i2c_stop();
    chk("wr_busy_end", 32'(busy), 0);
    chk("wr_ptr", 32'(reg_addr), 32'(m_ptr));
    chk("wr_drain", exp_wr.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, s;
    logic [7:0] d;
    int         p0, s0;
    reset = 1'b1; scl = 1'b1; m_low = 1'b0; load_bank = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    m_ptr = 8'h00;
    repeat (5) @(negedge clk);
    load_bank = 1'b0;
    chk("rst_sda", 32'(sda_bus), 1);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_re", 32'(reg_re), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write transfer
    wr_xfer(8'h05, 8'hA5, 8'h3C);
    chk("wr_final_ptr_lit", 32'(reg_addr), 32'h07);
    chk("wr_last_data_lit", 32'(bank[8'h06]), 32'h3C);

    // Read transfer with repeated START
    exp_rd.push_back(8'h10);
    exp_rd.push_back(8'h11);
    m_ptr = 8'h12;
    i2c_start();
    wr_byte(8'h90, a); chk("rd_ack_waddr", 32'(a), 1);
    wr_byte(8'h10, a); chk("rd_ack_ptr", 32'(a), 1);
    i2c_start();
    wr_byte(8'h91, a); chk("rd_ack_raddr", 32'(a), 1);
    rd_byte(d, 1'b1);  chk("rd_byte0", 32'(d), 32'h11);
    chk("rd_byte0_model", 32'(d), 32'(mem[8'h10]));
    rd_byte(d, 1'b0);  chk("rd_byte1", 32'(d), 32'h22);
    wq();
    chk("rd_release", 32'(sda_bus), 1);
    chk("rd_drain", exp_rd.size(), 0);
    i2c_stop();
    chk("rd_busy_end", 32'(busy), 0);
    chk("rd_ptr", 32'(reg_addr), 32'(m_ptr));

    // Address mismatch
    p0 = pulls; s0 = strobes;
    i2c_start();
    wr_byte(8'hA0, a); chk("mm_nack_addr", 32'(a), 0);
    chk("mm_busy", 32'(busy), 0);
    wr_byte(8'h05, a); chk("mm_nack_data", 32'(a), 0);
    i2c_stop();
    chk("mm_no_pull", pulls, p0);
    chk("mm_no_strobe", strobes, s0);
    chk("mm_ptr", 32'(reg_addr), 32'(m_ptr));

    // Pointer wrap
    wr_xfer(8'hFF, 8'h01, 8'h02);
    chk("wrap_ff", 32'(bank[8'hFF]), 32'h01);
    chk("wrap_00", 32'(bank[8'h00]), 32'h02);
    chk("wrap_ptr_lit", 32'(reg_addr), 32'h01);

    // Reset during the 4th bit of a read byte (0xA5: that bit is driven low)
    exp_rd.push_back(8'h40);
    i2c_start();
    wr_byte(8'h90, a); chk("mr_ack_waddr", 32'(a), 1);
    wr_byte(8'h40, a); chk("mr_ack_ptr", 32'(a), 1);
    i2c_start();
    wr_byte(8'h91, a); chk("mr_ack_raddr", 32'(a), 1);
    for (int i = 0; i < 3; i++) bit_io(1'b1, s);
    chk("mr_bit4_low", 32'(sda_bus), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_sda_z", 32'(sda_bus), 1);
    chk("mr_addr", 32'(reg_addr), 0);
    chk("mr_wdata", 32'(reg_wdata), 0);
    chk("mr_we", 32'(reg_we), 0);
    chk("mr_re", 32'(reg_re), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_drain", exp_rd.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 8'h00;
    i2c_stop();
    wr_xfer(8'h30, 8'h5A, 8'hC3);

    // Repeated START after the pointer ACK of a write
    exp_rd.push_back(8'h20);
    m_ptr = 8'h21;
    i2c_start();
    wr_byte(8'h90, a); chk("sr_ack_waddr", 32'(a), 1);
    wr_byte(8'h20, a); chk("sr_ack_ptr", 32'(a), 1);
    i2c_start();
    wr_byte(8'h91, a); chk("sr_ack_raddr", 32'(a), 1);
    chk("sr_busy", 32'(busy), 1);
    rd_byte(d, 1'b0);  chk("sr_byte_lit", 32'(d), 32'h77);
    chk("sr_byte_model", 32'(d), 32'(mem[8'h20]));
    i2c_stop();
    chk("sr_drain", exp_rd.size(), 0);
    chk("sr_ptr", 32'(reg_addr), 32'(m_ptr));
    chk("sr_busy_end", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
